// File: rtl/prbs_pkg.sv
// Shared definitions for the XNOR-feedback PRBS checker and its companion generator:
// FSM state encoding and the standard two-tap feedback pairs.
package prbs_pkg;

    typedef enum logic [1:0] {
        SEED   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } prbs_state_t;

    // Feedback tap pairs (1-based bit indices) for the supported polynomials.
    localparam int PRBS7_TAP_A  = 7;
    localparam int PRBS7_TAP_B  = 6;
    localparam int PRBS15_TAP_A = 15;
    localparam int PRBS15_TAP_B = 14;
    localparam int PRBS23_TAP_A = 23;
    localparam int PRBS23_TAP_B = 18;
    localparam int PRBS31_TAP_A = 31;
    localparam int PRBS31_TAP_B = 28;

endpackage

// File: rtl/prbs_xnor_step.sv
// One combinational step of a two-tap XNOR LFSR: predicted next bit and the
// register contents after shifting that bit in.
module prbs_xnor_step #(
    parameter int WIDTH = 7,
    parameter int TAP_A = 7,
    parameter int TAP_B = 6
) (
    input  logic [WIDTH-1:0] sr_i,
    output logic             bit_o,
    output logic [WIDTH-1:0] sr_next_o
);

    assign bit_o     = ~(sr_i[TAP_A-1] ^ sr_i[TAP_B-1]);
    assign sr_next_o = {sr_i[WIDTH-2:0], bit_o};

endmodule

// File: rtl/prbs_xnor_checker.sv
// Receive-side PRBS checker: seeds from the incoming stream, hunts for a clean run,
// then compares against a free-running local reference and counts bit errors.
module prbs_xnor_checker
    import prbs_pkg::*;
#(
    parameter int WIDTH    = PRBS7_TAP_A,
    parameter int TAP_A    = PRBS7_TAP_A,
    parameter int TAP_B    = PRBS7_TAP_B,
    parameter int LOCK_CNT = 16,
    parameter int WINDOW   = 64,
    parameter int LOSS_THR = 4,
    parameter int ERR_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             DIN,
    input  logic             CLR_ERR,
    output logic             LOCK,
    output logic             ERR,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             LOSS,
    output logic [1:0]       STATE_DBG
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int WBIT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int WEC_W  = $clog2(LOSS_THR + 1);

    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);
    localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_CNT - 1);
    localparam logic [WBIT_W-1:0] WBIT_LAST = WBIT_W'(WINDOW - 1);
    localparam logic [WEC_W-1:0]  WEC_THR   = WEC_W'(LOSS_THR);

    prbs_state_t       state_q, state_d;
    logic [WIDTH-1:0]  sr_q, sr_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WBIT_W-1:0] wbit_q, wbit_d;
    logic [WEC_W-1:0]  wec_q, wec_d;
    logic [ERR_W-1:0]  cnt_q, cnt_d;
    logic              lock_q, lock_d;
    logic              err_q, err_d;
    logic              loss_q, loss_d;

    logic              pred;
    logic [WIDTH-1:0]  sr_pred;
    logic [WIDTH-1:0]  sr_din;
    logic              mis;
    logic [WEC_W-1:0]  wec_sum;

    prbs_xnor_step #(
        .WIDTH (WIDTH),
        .TAP_A (TAP_A),
        .TAP_B (TAP_B)
    ) u_step (
        .sr_i      (sr_q),
        .bit_o     (pred),
        .sr_next_o (sr_pred)
    );

    assign sr_din  = {sr_q[WIDTH-2:0], DIN};
    assign mis     = DIN ^ pred;
    assign wec_sum = wec_q + WEC_W'(mis);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= SEED;
            sr_q    <= '0;
            fill_q  <= '0;
            run_q   <= '0;
            wbit_q  <= '0;
            wec_q   <= '0;
            cnt_q   <= '0;
            lock_q  <= 1'b0;
            err_q   <= 1'b0;
            loss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            run_q   <= run_d;
            wbit_q  <= wbit_d;
            wec_q   <= wec_d;
            cnt_q   <= cnt_d;
            lock_q  <= lock_d;
            err_q   <= err_d;
            loss_q  <= loss_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        run_d   = run_q;
        wbit_d  = wbit_q;
        wec_d   = wec_q;
        if (EN) begin
            unique case (state_q)
                SEED: begin
                    sr_d = sr_din;
                    if (fill_q == FILL_LAST) begin
                        state_d = HUNT;
                        fill_d  = '0;
                        run_d   = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                HUNT: begin
                    sr_d  = sr_din;
                    run_d = mis ? '0 : run_q + 1'b1;
                    // All-ones is the XNOR lockup state; it must never be accepted as a seed.
                    if (&sr_din) begin
                        state_d = SEED;
                        fill_d  = '0;
                        run_d   = '0;
                    end else if (!mis && run_q == RUN_LAST) begin
                        state_d = LOCKED;
                        wbit_d  = '0;
                        wec_d   = '0;
                    end
                end
                LOCKED: begin
                    // Reference free-runs so a received error never corrupts it.
                    sr_d = sr_pred;
                    if (wec_sum == WEC_THR) begin
                        state_d = SEED;
                        fill_d  = '0;
                        run_d   = '0;
                        wbit_d  = '0;
                        wec_d   = '0;
                    end else if (wbit_q == WBIT_LAST) begin
                        wbit_d = '0;
                        wec_d  = '0;
                    end else begin
                        wbit_d = wbit_q + 1'b1;
                        wec_d  = wec_sum;
                    end
                end
                default: state_d = SEED;
            endcase
        end
    end

    always_comb begin
        lock_d = (state_d == LOCKED);
        err_d  = EN && (state_q == LOCKED) && mis;
        loss_d = EN && (state_q == LOCKED) && (state_d == SEED);
        cnt_d  = cnt_q;
        if (EN) begin
            // Clear takes effect first, so an error on the same bit leaves a count of one.
            if (CLR_ERR) begin
                cnt_d = err_d ? ERR_W'(1) : '0;
            end else if (err_d && cnt_q != '1) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign LOCK      = lock_q;
    assign ERR       = err_q;
    assign ERR_CNT   = cnt_q;
    assign LOSS      = loss_q;
    assign STATE_DBG = state_q;

endmodule

// File: tb/tb_prbs_xnor_checker.sv
// Directed bench for prbs_xnor_checker: default instance plus a 4-bit error counter
// instance sharing the same stimulus.
module tb_prbs_xnor_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        din;
    logic        clr;
    logic        lock_a, err_a, loss_a;
    logic [15:0] cnt_a;
    logic [1:0]  st_a;
    logic        lock_b, err_b, loss_b;
    logic [3:0]  cnt_b;
    logic [1:0]  st_b;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [6:0]  gen_sr;
    logic        err_seen;
    logic        lock_seen;
    logic        saw_seed;
    logic        saw_hunt;

    always #5 clk = ~clk;

    prbs_xnor_checker dut_a (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .DIN       (din),
        .CLR_ERR   (clr),
        .LOCK      (lock_a),
        .ERR       (err_a),
        .ERR_CNT   (cnt_a),
        .LOSS      (loss_a),
        .STATE_DBG (st_a)
    );

    prbs_xnor_checker #(.ERR_W(4)) dut_b (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .DIN       (din),
        .CLR_ERR   (clr),
        .LOCK      (lock_b),
        .ERR       (err_b),
        .ERR_CNT   (cnt_b),
        .LOSS      (loss_b),
        .STATE_DBG (st_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic b, input logic e, input logic c);
        @(negedge clk);
        en  = e;
        din = b;
        clr = c;
        @(posedge clk);
        #1;
    endtask

    // Advance the reference PRBS7 generator one bit and send it, optionally inverted.
    task automatic send_gen(input logic flip, input logic c);
        logic b;
        b      = ~(gen_sr[6] ^ gen_sr[5]);
        gen_sr = {gen_sr[5:0], b};
        drive(b ^ flip, 1'b1, c);
    endtask

    task automatic send_clean(input int n);
        for (int i = 0; i < n; i++) begin
            send_gen(1'b0, 1'b0);
            err_seen = err_seen | err_a;
        end
    endtask

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        din      = 1'b0;
        clr      = 1'b0;
        gen_sr   = '0;
        err_seen = 1'b0;
        #12;
        chk("rst_lock",  32'(lock_a), 0);
        chk("rst_err",   32'(err_a),  0);
        chk("rst_loss",  32'(loss_a), 0);
        chk("rst_cnt",   32'(cnt_a),  0);
        chk("rst_state", 32'(st_a),   0);
        @(negedge clk);
        rst = 1'b0;

        // Clean stream from seed 0: lock on the 23rd bit.
        for (int i = 1; i <= 23; i++) begin
            send_gen(1'b0, 1'b0);
            err_seen = err_seen | err_a;
            if (i == 7)  chk("hunt_after_fill", 32'(st_a), 1);
            if (i == 22) chk("no_lock_bit22", 32'(lock_a), 0);
        end
        chk("lock_bit23",   32'(lock_a), 1);
        chk("lock_b_bit23", 32'(lock_b), 1);
        send_clean(176);
        chk("clean_no_err", 32'(err_seen), 0);
        chk("clean_cnt0",   32'(cnt_a), 0);

        // Single flipped bit 200.
        send_gen(1'b1, 1'b0);
        chk("flip200_err",  32'(err_a),  1);
        chk("flip200_cnt",  32'(cnt_a),  1);
        chk("flip200_lock", 32'(lock_a), 1);
        err_seen = 1'b0;
        send_clean(100);
        chk("post_flip_no_err", 32'(err_seen), 0);
        chk("post_flip_cnt",    32'(cnt_a), 1);
        send_clean(699);
        chk("bit999_lock",   32'(lock_a), 1);
        chk("bit999_no_err", 32'(err_seen), 0);

        // Clear without an error, then four errors in one window.
        send_gen(1'b0, 1'b1);
        chk("clr_cnt", 32'(cnt_a), 0);
        send_gen(1'b1, 1'b0);
        send_gen(1'b1, 1'b0);
        send_gen(1'b1, 1'b0);
        chk("three_err_lock", 32'(lock_a), 1);
        chk("three_err_loss", 32'(loss_a), 0);
        send_gen(1'b1, 1'b0);
        chk("loss_pulse", 32'(loss_a), 1);
        chk("loss_lock",  32'(lock_a), 0);
        chk("loss_cnt_a", 32'(cnt_a),  4);
        chk("loss_cnt_b", 32'(cnt_b),  4);
        send_gen(1'b0, 1'b0);
        chk("loss_one_cycle", 32'(loss_a), 0);
        send_clean(21);
        chk("relock_bit22", 32'(lock_a), 0);
        send_gen(1'b0, 1'b0);
        chk("relock_bit23", 32'(lock_a), 1);

        // Three errors at the tail of each of six windows: saturation without loss.
        send_gen(1'b0, 1'b1);
        chk("sat_clr", 32'(cnt_a), 0);
        send_clean(60);
        for (int w = 0; w < 6; w++) begin
            send_gen(1'b1, 1'b0);
            send_gen(1'b1, 1'b0);
            send_gen(1'b1, 1'b0);
            if (w < 5) send_clean(61);
        end
        chk("sat_lock_a", 32'(lock_a), 1);
        chk("sat_lock_b", 32'(lock_b), 1);
        chk("sat_cnt_a",  32'(cnt_a),  18);
        chk("sat_cnt_b",  32'(cnt_b),  15);

        // Clear coincident with an error, then a fourth error on the window wrap bit.
        send_gen(1'b1, 1'b1);
        chk("clr_err_cnt_a", 32'(cnt_a), 1);
        chk("clr_err_cnt_b", 32'(cnt_b), 1);
        send_clean(60);
        send_gen(1'b1, 1'b0);
        send_gen(1'b1, 1'b0);
        chk("wrap_pre_lock", 32'(lock_a), 1);
        send_gen(1'b1, 1'b0);
        chk("wrap_loss", 32'(loss_a), 1);
        chk("wrap_lock", 32'(lock_a), 0);
        chk("wrap_cnt",  32'(cnt_a),  4);

        // Constant ones never lock; FSM bounces between SEED and HUNT.
        lock_seen = 1'b0;
        saw_seed  = 1'b0;
        saw_hunt  = 1'b0;
        for (int i = 0; i < 500; i++) begin
            drive(1'b1, 1'b1, 1'b0);
            lock_seen = lock_seen | lock_a;
            if (st_a == 2'd0) saw_seed = 1'b1;
            if (st_a == 2'd1) saw_hunt = 1'b1;
        end
        chk("ones_no_lock",  32'(lock_seen), 0);
        chk("ones_saw_seed", 32'(saw_seed),  1);
        chk("ones_saw_hunt", 32'(saw_hunt),  1);
        chk("ones_cnt_kept", 32'(cnt_a),     4);

        // Fresh start with EN toggling every cycle.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        gen_sr = '0;
        chk("rst2_cnt", 32'(cnt_a), 0);
        err_seen = 1'b0;
        for (int i = 1; i <= 23; i++) begin
            logic r;
            send_gen(1'b0, 1'b0);
            if (i == 22) chk("en_no_lock_bit22", 32'(lock_a), 0);
            if (i == 23) chk("en_lock_bit23",    32'(lock_a), 1);
            r = 1'($urandom_range(0, 1));
            drive(r, 1'b0, 1'b0);
            err_seen = err_seen | err_a;
        end
        chk("en_idle_no_err", 32'(err_seen), 0);
        chk("en_idle_lock",   32'(lock_a),   1);
        send_gen(1'b1, 1'b0);
        chk("en_err",     32'(err_a), 1);
        chk("en_err_cnt", 32'(cnt_a), 1);
        drive(1'b0, 1'b0, 1'b1);
        chk("en_off_err",  32'(err_a),  0);
        chk("en_off_cnt",  32'(cnt_a),  1);
        chk("en_off_lock", 32'(lock_a), 1);

        // Asynchronous reset between edges.
        #2;
        rst = 1'b1;
        #1;
        chk("async_lock",  32'(lock_a), 0);
        chk("async_cnt_a", 32'(cnt_a),  0);
        chk("async_cnt_b", 32'(cnt_b),  0);
        chk("async_loss",  32'(loss_a), 0);
        @(negedge clk);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs_xnor_checker.md
Name: prbs_xnor_checker

Overview:
- Receive-side checker for the XNOR-feedback two-tap LFSR PRBS streams our test structures emit (PRBS7/15/23/31).
- Self-synchronises to a serial bit stream, declares lock, then compares each received bit against a free-running local reference.
- Counts bit errors and drops lock on excessive error density.
- Sits behind the pad/deserialiser in the BIST path; outputs go to the status register block.

Parameters:
- WIDTH, 7: LFSR length; the sequence has period 2^WIDTH-1.
- TAP_A, 7: first feedback tap (1-based bit index).
- TAP_B, 6: second feedback tap (1-based); the predicted bit is XNOR(sr[TAP_A-1], sr[TAP_B-1]).
- LOCK_CNT, 16: consecutive matching bits required in HUNT to declare lock.
- WINDOW, 64: window length in valid bits for loss-of-lock detection.
- LOSS_THR, 4: number of errors within one window that drops lock.
- ERR_W, 16: width of the saturating error counter.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- EN  input  1  DIN is valid this cycle; all state advances only when EN=1.
- DIN  input  1  received serial bit.
- CLR_ERR  input  1  synchronous clear of ERR_CNT.
- LOCK  output  1  registered; 1 while in LOCKED.
- ERR  output  1  registered one-cycle pulse per mismatching bit while LOCKED.
- ERR_CNT  output  ERR_W  saturating count of errors seen while LOCKED.
- LOSS  output  1  registered one-cycle pulse on the LOCKED->SEED transition.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: LOCK=0, ERR=0, LOSS=0, ERR_CNT=0, sr=0, state=SEED, all internal counters 0.
- Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Predicted bit p = XNOR(sr[TAP_A-1], sr[TAP_B-1]). Mismatch m = DIN ^ p.
- States and transitions (all evaluated only on cycles with EN=1):
  - SEED: sr <= {sr[WIDTH-2:0], DIN}; fill counter increments. After WIDTH valid bits go to HUNT with run counter = 0.
  - HUNT: sr shifts in DIN.
    - If m=1: run counter = 0.
    - Else: run counter increments.
    - If sr is all-ones (the XNOR lockup state): return to SEED, fill counter = 0. An all-ones stream never locks.
    - When the run counter reaches LOCK_CNT: go to LOCKED, and LOCK goes to 1 on that same edge.
  - LOCKED: sr shifts in p, not DIN, so errors do not propagate into the reference.
    - m=1: ERR pulses on the next cycle.
    - ERR_CNT increments and saturates at 2^ERR_W-1.
    - The window error counter increments.
    - The window bit counter free-runs from 0 on LOCKED entry and wraps at WINDOW-1; on wrap the window error counter clears.
    - If the window error count reaches LOSS_THR: go to SEED, LOCK=0, LOSS pulses for one cycle. ERR_CNT is retained.
- Latency: ERR, LOCK and LOSS all change on the clock edge that samples the relevant EN/DIN; this is a one-cycle registered latency.
- Clean lock: occurs on the (WIDTH+LOCK_CNT)th valid bit after reset.
- EN=0 cycles: hold all state; ERR=0 and LOSS=0.
- CLR_ERR:
  - With no simultaneous error: ERR_CNT <= 0.
  - With an error in the same cycle: ERR_CNT <= 1 (clear, then count).
  - CLR_ERR does not touch window counters or state.
- Error on the window wrap bit: counted into the window that is closing, then the window clears.

Decomposition:
- Shared package prbs_pkg holds:
  - the state enum (SEED, HUNT, LOCKED);
  - tap constant pairs PRBS7 (7,6), PRBS15 (15,14), PRBS23 (23,18), PRBS31 (31,28).
- One sub-module, prbs_xnor_step: combinational next-bit/next-state of the XNOR LFSR. The companion generator reuses it.

Test Plan:
- Clean PRBS7 stream from seed 0, EN=1 every cycle -> LOCK rises after the 23rd bit. ERR never asserts over 1000 bits; ERR_CNT=0.
- Locked, flip bit 200 -> single ERR pulse on the next cycle; ERR_CNT=1; LOCK stays 1; the next 100 bits are clean with no further ERR.
- Locked, flip 4 bits within one 64-bit window -> LOSS pulse and LOCK=0 after the 4th error; ERR_CNT=4; re-lock after 23 further clean bits.
- DIN constant 1 for 500 bits -> LOCK stays 0 throughout; the FSM cycles SEED/HUNT.
- ERR_W=4, inject 3 errors per window across 6 windows -> ERR_CNT saturates at 15 with LOCK held. CLR_ERR coincident with an error -> ERR_CNT=1.
- Assert RST mid-lock between clock edges -> LOCK, ERR_CNT and LOSS are 0 immediately. EN toggling 50% -> lock occurs on the 23rd valid bit.
